// File: rtl/pipe_ctrl.sv
// Pipeline control: turns hazard/branch/memory-busy requests into register enables,
// flushes and bubbles, and tracks stage valid bits, mode, a stall watchdog and counters.
module pipe_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STALL_LIMIT = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             Stall,
  input  logic             Branch_Taken,
  input  logic             Mem_Busy,
  input  logic             INST_VALID,
  output logic             PC_EN,
  output logic             IFID_EN,
  output logic             IFID_FLUSH,
  output logic             IDEX_BUBBLE,
  output logic             PIPE_EN,
  output logic             V_ID,
  output logic             V_EX,
  output logic             V_MEM,
  output logic             V_WB,
  output logic [1:0]       MODE,
  output logic             DEADLOCK,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
);

  localparam logic [1:0] MODE_RUN   = 2'd0;
  localparam logic [1:0] MODE_STALL = 2'd1;
  localparam logic [1:0] MODE_MWAIT = 2'd2;

  // Run counter only needs to reach STALL_LIMIT+1, where it parks.
  localparam int unsigned RUN_W = $clog2(STALL_LIMIT + 2);
  localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]       mode_nxt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_nxt;

  // Request decode, priority Mem_Busy > Stall > Branch_Taken; all quiet in reset.
  always_comb begin
    PC_EN       = 1'b0;
    IFID_EN     = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_BUBBLE = 1'b0;
    PIPE_EN     = 1'b0;
    mode_nxt    = MODE_RUN;
    if (!RSTN) begin
      mode_nxt = MODE_RUN;
    end else if (Mem_Busy) begin
      mode_nxt = MODE_MWAIT;
    end else if (Stall) begin
      IDEX_BUBBLE = 1'b1;
      PIPE_EN     = 1'b1;
      mode_nxt    = MODE_STALL;
    end else begin
      PC_EN      = 1'b1;
      IFID_EN    = 1'b1;
      PIPE_EN    = 1'b1;
      IFID_FLUSH = Branch_Taken;
    end
  end

  // Consecutive-stall length; frozen while memory is busy.
  always_comb begin
    run_nxt = run_cnt;
    if (!Mem_Busy) begin
      if (!Stall)
        run_nxt = '0;
      else if (run_cnt != RUN_TRIP)
        run_nxt = RUN_W'(run_cnt + 1'b1);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) MODE <= MODE_RUN;
    else       MODE <= mode_nxt;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      V_ID  <= 1'b0;
      V_EX  <= 1'b0;
      V_MEM <= 1'b0;
      V_WB  <= 1'b0;
    end else if (PIPE_EN) begin
      V_WB  <= V_MEM;
      V_MEM <= V_EX;
      V_EX  <= IDEX_BUBBLE ? 1'b0 : V_ID;
      V_ID  <= IFID_FLUSH ? 1'b0 : (IFID_EN ? INST_VALID : V_ID);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      run_cnt  <= '0;
      DEADLOCK <= 1'b0;
    end else begin
      run_cnt  <= run_nxt;
      DEADLOCK <= DEADLOCK | (run_nxt == RUN_TRIP);
    end
  end

  // Saturating event counters.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (!PC_EN && STALL_CNT != CNT_MAX)
        STALL_CNT <= CNT_W'(STALL_CNT + 1'b1);
      if (IFID_FLUSH && FLUSH_CNT != CNT_MAX)
        FLUSH_CNT <= CNT_W'(FLUSH_CNT + 1'b1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a 2-bit-counter instance on shared inputs.
module tb_pipe_ctrl;

  logic CLK = 1'b0;
  logic RSTN;
  logic Stall, Branch_Taken, Mem_Busy, INST_VALID;

  logic PC_EN, IFID_EN, IFID_FLUSH, IDEX_BUBBLE, PIPE_EN;
  logic V_ID, V_EX, V_MEM, V_WB, DEADLOCK;
  logic [1:0]  MODE;
  logic [15:0] STALL_CNT, FLUSH_CNT;

  logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_pipe_en;
  logic s_v_id, s_v_ex, s_v_mem, s_v_wb, s_deadlock;
  logic [1:0] s_mode, s_stall_cnt, s_flush_cnt;

  logic [3:0] vbits;
  logic [4:0] ens;
  assign vbits = {V_ID, V_EX, V_MEM, V_WB};
  assign ens   = {PC_EN, IFID_EN, PIPE_EN, IFID_FLUSH, IDEX_BUBBLE};

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  pipe_ctrl u_dut (
    .CLK(CLK), .RSTN(RSTN), .Stall(Stall), .Branch_Taken(Branch_Taken),
    .Mem_Busy(Mem_Busy), .INST_VALID(INST_VALID),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_FLUSH(IFID_FLUSH),
    .IDEX_BUBBLE(IDEX_BUBBLE), .PIPE_EN(PIPE_EN),
    .V_ID(V_ID), .V_EX(V_EX), .V_MEM(V_MEM), .V_WB(V_WB),
    .MODE(MODE), .DEADLOCK(DEADLOCK), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  pipe_ctrl #(.CNT_W(2), .STALL_LIMIT(4)) u_sat (
    .CLK(CLK), .RSTN(RSTN), .Stall(Stall), .Branch_Taken(Branch_Taken),
    .Mem_Busy(Mem_Busy), .INST_VALID(INST_VALID),
    .PC_EN(s_pc_en), .IFID_EN(s_ifid_en), .IFID_FLUSH(s_ifid_flush),
    .IDEX_BUBBLE(s_idex_bubble), .PIPE_EN(s_pipe_en),
    .V_ID(s_v_id), .V_EX(s_v_ex), .V_MEM(s_v_mem), .V_WB(s_v_wb),
    .MODE(s_mode), .DEADLOCK(s_deadlock), .STALL_CNT(s_stall_cnt), .FLUSH_CNT(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RSTN = 1'b0; Stall = 1'b0; Branch_Taken = 1'b0; Mem_Busy = 1'b0; INST_VALID = 1'b0;
    #12;
    chk("rst_v",     32'(vbits), 32'h0);
    chk("rst_mode",  32'(MODE), 32'h0);
    chk("rst_dl",    32'(DEADLOCK), 32'h0);
    chk("rst_scnt",  32'(STALL_CNT), 32'h0);
    chk("rst_fcnt",  32'(FLUSH_CNT), 32'h0);
    chk("rst_en",    32'(ens), 32'h0);

    // Fill the pipeline
    RSTN = 1'b1; INST_VALID = 1'b1; #1;
    chk("run_en", 32'(ens), 32'b11100);
    repeat (4) tick();
    chk("fill_v",    32'(vbits), 32'b1111);
    chk("fill_mode", 32'(MODE), 32'h0);

    // Single load-use stall
    Stall = 1'b1; #1;
    chk("stall_en", 32'(ens), 32'b00101);
    tick(); Stall = 1'b0;
    chk("stall_v",    32'(vbits), 32'b1011);
    chk("stall_mode", 32'(MODE), 32'h1);
    chk("stall_cnt1", 32'(STALL_CNT), 32'h1);

    // Taken branch flushes IF/ID
    Branch_Taken = 1'b1; #1;
    chk("br_en", 32'(ens), 32'b11110);
    tick();
    chk("br_v",    32'(vbits), 32'b0101);
    chk("br_fcnt", 32'(FLUSH_CNT), 32'h1);
    chk("br_mode", 32'(MODE), 32'h0);

    // Stall outranks branch: no flush
    Stall = 1'b1; #1;
    chk("brst_en", 32'(ens), 32'b00101);
    tick(); Stall = 1'b0; Branch_Taken = 1'b0;
    chk("brst_fcnt", 32'(FLUSH_CNT), 32'h1);
    chk("brst_scnt", 32'(STALL_CNT), 32'h2);
    chk("brst_v",    32'(vbits), 32'b0010);

    // Memory busy with a stall request freezes everything (3 more stall cycles)
    Mem_Busy = 1'b1; Stall = 1'b1; #1;
    chk("mw_en", 32'(ens), 32'b00000);
    repeat (3) tick();
    chk("mw_v",    32'(vbits), 32'b0010);
    chk("mw_mode", 32'(MODE), 32'h2);
    chk("mw_scnt", 32'(STALL_CNT), 32'h5);
    chk("mw_dl",   32'(DEADLOCK), 32'h0);
    Mem_Busy = 1'b0; Stall = 1'b0;
    tick();
    chk("mw_exit_mode", 32'(MODE), 32'h0);

    // Run length holds across Mem_Busy: 3 + (busy 2) + 2 stall cycles trips the watchdog
    Stall = 1'b1;
    repeat (3) tick();
    Mem_Busy = 1'b1;
    repeat (2) tick();
    chk("dl_busy_hold", 32'(DEADLOCK), 32'h0);
    Mem_Busy = 1'b0;
    tick();
    chk("dl_run4", 32'(DEADLOCK), 32'h0);
    tick();
    chk("dl_run5", 32'(DEADLOCK), 32'h1);
    Stall = 1'b0;
    repeat (2) tick();
    chk("dl_sticky", 32'(DEADLOCK), 32'h1);

    // Asynchronous reset in the middle of an MWAIT cycle
    Mem_Busy = 1'b1; Stall = 1'b1;
    tick();
    chk("pre_rst_mode", 32'(MODE), 32'h2);
    #2 RSTN = 1'b0; #1;
    chk("arst_v",    32'(vbits), 32'h0);
    chk("arst_mode", 32'(MODE), 32'h0);
    chk("arst_dl",   32'(DEADLOCK), 32'h0);
    chk("arst_scnt", 32'(STALL_CNT), 32'h0);
    chk("arst_en",   32'(ens), 32'h0);
    Mem_Busy = 1'b0; Stall = 1'b0;
    tick();
    RSTN = 1'b1;
    tick();
    chk("post_rst_mode", 32'(MODE), 32'h0);
    chk("post_rst_v",    32'(vbits), 32'b1000);

    // Broken stall runs never trip the watchdog
    Stall = 1'b1; repeat (4) tick();
    Stall = 1'b0; tick();
    Stall = 1'b1; repeat (4) tick();
    Stall = 1'b0; tick();
    chk("dl_broken", 32'(DEADLOCK), 32'h0);
    chk("scnt8",     32'(STALL_CNT), 32'h8);

    // Five consecutive stalls: trips on the fifth edge; 2-bit counter saturates
    Stall = 1'b1;
    repeat (4) tick();
    chk("dl_4th", 32'(DEADLOCK), 32'h0);
    tick();
    chk("dl_5th",    32'(DEADLOCK), 32'h1);
    chk("scnt13",    32'(STALL_CNT), 32'd13);
    chk("sat_scnt",  32'(s_stall_cnt), 32'h3);
    chk("sat_dl",    32'(s_deadlock), 32'h1);
    Stall = 1'b0;
    repeat (2) tick();
    chk("dl_hold", 32'(DEADLOCK), 32'h1);
    chk("sat_hold", 32'(s_stall_cnt), 32'h3);
    #2 RSTN = 1'b0; #1;
    chk("dl_clear",       32'(DEADLOCK), 32'h0);
    chk("sat_scnt_clear", 32'(s_stall_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
